// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin output arbiter.
// Selection indices and output-stage state live here so every file agrees on widths.
package rr_mux_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_e;

    // The next pointer wraps naturally in SEL_W bits, so 3 + 1 gives 0.
    function automatic sel_t sel_next(input sel_t s);
        return s + sel_t'(1);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_4_pick.sv
// Round-robin pick over four requests. The requests are rotated so that ptr lands at position 0.
// A fixed-priority pick then chooses the lowest set position, and the result is un-rotated.
module rr_pick_4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output sel_t             gnt,
    output logic             any
);

    logic [N_REQ-1:0] w_rot;
    sel_t             w_off;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_rot = '0;
        w_off = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_rot[i] = req[sel_t'(i) + ptr];
        end
        // A descending scan lets the lowest set position overwrite the higher ones.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = sel_t'(i);
            end
        end
    end

    assign gnt = w_off + ptr;
    assign any = |req;

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// Four valid/ready requesters time-share one W-bit output register under round-robin arbitration.
// The register reports the winning source index. A word accepted at an edge is visible from that edge.
module rr_mux_arbiter_4
    import rr_mux_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data_0,
    input  logic [W-1:0] in_data_1,
    input  logic [W-1:0] in_data_2,
    input  logic [W-1:0] in_data_3,
    output logic [3:0]   in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_ready
);

    ostate_e      r_state;
    ostate_e      w_state_nxt;
    sel_t         r_ptr;
    logic [W-1:0] r_data;
    sel_t         r_src;

    sel_t         w_gnt;
    logic         w_any;
    logic         w_load;
    logic         w_accept;
    logic [W-1:0] w_sel_data;

    rr_pick_4 u_pick (
        .req (in_valid),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .any (w_any)
    );

    // The register can take a new word when it is empty, or when its current word leaves this cycle.
    assign w_load   = (r_state == EMPTY) | out_ready;
    assign w_accept = w_load & w_any & ~rst;

    always_comb begin
        in_ready        = '0;
        in_ready[w_gnt] = w_accept;
    end

    always_comb begin
        w_sel_data = in_data_0;
        unique case (w_gnt)
            2'd0: w_sel_data = in_data_0;
            2'd1: w_sel_data = in_data_1;
            2'd2: w_sel_data = in_data_2;
            2'd3: w_sel_data = in_data_3;
            default: w_sel_data = in_data_0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            EMPTY: if (w_accept) w_state_nxt = FULL;
            FULL:  if (out_ready && !w_accept) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignment, so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_src   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= w_sel_data;
                r_src  <= w_gnt;
                r_ptr  <= sel_next(w_gnt);
            end
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed and randomized checks for rr_mux_arbiter_4. The scenarios cover reset, rotation, backpressure,
// skip/wrap and drain, and a soak run compares the design against a small bench-side model.
module tb_rr_mux_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] in_valid;
    logic [3:0] d [4];
    logic [3:0] in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_src;
    logic       out_ready;

    int n_vec = 0;
    int n_err = 0;

    rr_mux_arbiter_4 #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data_0 (d[0]),
        .in_data_1 (d[1]),
        .in_data_2 (d[2]),
        .in_data_3 (d[3]),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        tick();
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 4'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_vec++; if (out_src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", out_src); end
        n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        rst = 1'b0;
        in_valid = 4'b0001;
        out_ready = 1'b0;
        d[0] = 4'hA;
        tick();
        n_vec++; if (out_data !== 4'hA || out_valid !== 1'b1) begin n_err++; $display("FAIL preload: got v=%b d=%h want v=1 d=a", out_valid, out_data); end
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 4'h0) begin n_err++; $display("FAIL async_rst_data: got %h want 0", out_data); end
        n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL async_rst_in_ready: got %b want 0000", in_ready); end
        tick();
        rst = 1'b0;
        in_valid = 4'b0100;
        d[2] = 4'h7;
        tick();
        n_vec++; if (out_src !== 2'd2 || out_valid !== 1'b1) begin n_err++; $display("FAIL post_rst_src: got v=%b src=%0d want v=1 src=2", out_valid, out_src); end
    endtask

    task automatic test_round_robin;
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        in_valid = 4'b1111;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_first_ready: got %b want 0001", in_ready); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 4'(k % 4 + 1)) begin
                n_err++;
                $display("FAIL rr_seq[%0d]: got v=%b src=%0d d=%0d want v=1 src=%0d d=%0d",
                         k, out_valid, out_src, out_data, k % 4, k % 4 + 1);
            end
            n_vec++;
            if (in_ready !== 4'(1 << ((k + 1) % 4))) begin
                n_err++;
                $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << ((k + 1) % 4)));
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b1111;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready); end
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'd2) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b src=%0d d=%0d want v=1 src=1 d=2", k, out_valid, out_src, out_data);
            end
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL bp_release_ready: got %b want 0100", in_ready); end
        tick();
        n_vec++; if (out_src !== 2'd2 || out_data !== 4'd3) begin n_err++; $display("FAIL bp_release_out: got src=%0d d=%0d want src=2 d=3", out_src, out_data); end
    endtask

    task automatic test_skip_wrap;
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        out_ready = 1'b1;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0010;
        #1;
        n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL skip_ready: got %b want 0010", in_ready); end
        tick();
        n_vec++; if (out_src !== 2'd1 || out_data !== 4'd2) begin n_err++; $display("FAIL skip_out: got src=%0d d=%0d want src=1 d=2", out_src, out_data); end
        in_valid = 4'b1001;
        #1;
        n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ready: got %b want 1000", in_ready); end
        tick();
        n_vec++; if (out_src !== 2'd3 || out_data !== 4'd4) begin n_err++; $display("FAIL wrap_out: got src=%0d d=%0d want src=3 d=4", out_src, out_data); end
        in_valid = 4'b1111;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ptr_zero: got %b want 0001", in_ready); end
        tick();
    endtask

    task automatic test_drain;
        do_reset();
        for (int i = 0; i < 4; i++) d[i] = 4'(i + 1);
        out_ready = 1'b1;
        in_valid = 4'b0010;
        tick();
        in_valid = 4'b0000;
        #1;
        n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL drain_ready: got %b want 0000", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
        in_valid = 4'b1111;
        #1;
        n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL drain_ptr_kept: got %b want 0100", in_ready); end
        tick();
        in_valid = 4'b0001;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL single_req: got %b want 0001", in_ready); end
        tick();
        n_vec++; if (out_src !== 2'd0 || out_data !== 4'd1) begin n_err++; $display("FAIL single_out: got src=%0d d=%0d want src=0 d=1", out_src, out_data); end
    endtask

    task automatic test_soak;
        int   sent [4];
        int   got [4];
        int   waitc [4];
        logic m_full;
        logic [1:0] m_ptr;
        logic [1:0] m_src;
        logic [3:0] m_data;
        logic [3:0] exp_rdy;
        int   g;
        bit   fnd;
        int   prints;
        do_reset();
        for (int i = 0; i < 4; i++) begin sent[i] = 0; got[i] = 0; waitc[i] = 0; end
        m_full = 1'b0;
        m_ptr = 2'd0;
        m_src = 2'd0;
        m_data = 4'd0;
        prints = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] && $urandom_range(0, 1) == 1) begin
                    in_valid[i] = 1'b1;
                    d[i] = 4'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = '0;
            fnd = 1'b0;
            g = 0;
            if (!m_full || out_ready) begin
                for (int k = 0; k < 4; k++) begin
                    if (!fnd && in_valid[(int'(m_ptr) + k) % 4]) begin
                        fnd = 1'b1;
                        g = (int'(m_ptr) + k) % 4;
                    end
                end
            end
            if (fnd) exp_rdy[g] = 1'b1;
            n_vec++;
            if ($countones(in_ready) > 1) begin
                n_err++;
                if (prints++ < 20) $display("FAIL soak_onehot cyc %0d: got %b want at most one bit", cyc, in_ready);
            end
            n_vec++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                if (prints++ < 20) $display("FAIL soak_ready cyc %0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            if (m_full && out_ready) got[m_src]++;
            if (fnd) begin
                sent[g]++;
                for (int k = 0; k < 4; k++) if (k != g && in_valid[k]) waitc[k]++;
                waitc[g] = 0;
                m_full = 1'b1;
                m_src = 2'(g);
                m_data = d[g];
                m_ptr = 2'(g + 1);
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            n_vec++;
            if (waitc[0] > 3 || waitc[1] > 3 || waitc[2] > 3 || waitc[3] > 3) begin
                n_err++;
                if (prints++ < 20) $display("FAIL soak_fairness cyc %0d: got waits %0d %0d %0d %0d want <=3",
                                            cyc, waitc[0], waitc[1], waitc[2], waitc[3]);
            end
            tick();
            if (fnd) in_valid[g] = 1'b0;
            n_vec++;
            if (out_valid !== m_full || (m_full && (out_data !== m_data || out_src !== m_src))) begin
                n_err++;
                if (prints++ < 20) $display("FAIL soak_out cyc %0d: got v=%b src=%0d d=%h want v=%b src=%0d d=%h",
                                            cyc, out_valid, out_src, out_data, m_full, m_src, m_data);
            end
        end
        if (m_full) got[m_src]++;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (sent[i] != got[i]) begin
                n_err++;
                $display("FAIL soak_scoreboard src %0d: got %0d delivered want %0d accepted", i, got[i], sent[i]);
            end
        end
        in_valid = '0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_skip_wrap();
        test_drain();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter that shares one W-bit output channel between four valid/ready requesters.
- Selects one requester per transfer, steers its data through a 4:1 select and registers it into a one-entry output stage.
- Reports the source index alongside the data.
- Sits in front of any single-consumer datapath that several producers must time-share.

Parameters:
- W, 4, data width of every requester and of the output.
- N_REQ, 4, number of requesters; fixed at 4, not to be overridden; grant index is 2 bits.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  bit i set: requester i offers in_data_i.
- in_data_0 .. in_data_3  input  W each  requester payloads.
- in_ready  output  4  one-hot or zero; bit i set: requester i's word is accepted this cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  W  registered payload.
- out_src  output  2  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately, and mid-transfer): out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - A held word is discarded.
  - in_ready goes 0 while rst is high.
- Output stage state machine, state equals out_valid:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready=1 and no accept.
  - FULL stays FULL on out_ready=1 with accept (back-to-back) or on out_ready=0.
- load = (state==EMPTY) | out_ready. This is combinational, so out_ready feeds in_ready in the same cycle.
- Grant (combinational):
  - Scan in_valid starting at rr_ptr, ascending with wrap 3->0.
  - The first set bit wins (gnt, 2 bits). any = |in_valid.
- in_ready[gnt] = load & any. All other in_ready bits are 0. At most one bit is ever set.
- Accept (in_ready[gnt]=1) at the edge:
  - out_data <= in_data_gnt, out_src <= gnt, out_valid <= 1.
  - rr_ptr <= gnt+1 mod 4.
- No accept: rr_ptr holds.
- FULL with out_ready=0: out_data and out_src stay stable; in_ready=0.
- Latency: a word accepted at edge k is visible on out_* from edge k.
- Throughput: one transfer per cycle when out_ready is held at 1.
- Fairness: with all four requesting continuously, the grant order is ptr, ptr+1, ptr+2, ptr+3. Any requester holding valid is served within 4 accepts.
- A requester that deasserts valid before being granted is skipped without penalty. The pointer moves only on an accept.
- Requesters must hold in_valid and in_data stable until in_ready; violations are not detected.
- Single requester: it is granted every load cycle regardless of rr_ptr.
- Wrap-around: gnt=3 gives rr_ptr=0.

Decomposition:
- Package rr_mux_arbiter_pkg holds:
  - localparam N_REQ=4, SEL_W=2.
  - typedef logic [SEL_W-1:0] sel_t.
  - typedef enum logic {EMPTY, FULL} ostate_e.
- Sub-module rr_pick_4: combinational.
  - Inputs: req[3:0] and ptr (sel_t).
  - Outputs: gnt (sel_t) and any.
  - Implemented as a rotate, fixed-priority pick, and un-rotate.
- Data select is an inline gnt-indexed 4:1 mux in the top module.

Test Plan:
- Reset mid-operation: FULL with out_data=4'hA, assert rst asynchronously between edges -> out_valid=0, out_data=0 and in_ready=0 immediately. After release, in_valid=4'b0100 -> out_src=2.
- All requesting, out_ready=1, data_i=i+1, starting from reset (rr_ptr=0) -> out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1; out_valid stays 1.
- Backpressure: FULL with out_src=1, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0 and out_data/out_src stable. On out_ready=1 -> requester 2 accepted that cycle.
- Skip and wrap: rr_ptr=3, in_valid=4'b0010 -> gnt=1, rr_ptr becomes 2. Then in_valid=4'b1001 -> gnt=3, rr_ptr becomes 0.
- Drain: single word accepted, then in_valid=0 and out_ready=1 -> out_valid falls to 0 at the next edge and rr_ptr is unchanged.
- Random soak of 10k cycles with a scoreboard per source:
  - No word lost or duplicated.
  - in_ready is always one-hot or zero.
  - Every persistently requesting source is served within 4 accepts.
